// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_mem_ctrl : byte/half/word load-store sequencer onto a word-wide memory
// Revision    : 1.0
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int WORD_ADDR = 1,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] mem_A_in,
   output logic [31:0]       mem_D_in,
   output logic              mem_WE,
   input  logic [31:0]       mem_D_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0010;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1010;

   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [3:0]        r_op;
   logic [1:0]        r_lane;
   logic [15:0]       r_wdata;
   logic              r_err;
   logic              w_accept;
   logic              w_legal;
   logic              w_misal;
   logic              w_acc_err;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load;
   logic [31:0]       w_merged;

   generate
      if (WORD_ADDR != 0) begin : g_word_index
         assign w_mem_addr = addr >> 2;
      end else begin : g_byte_aligned
         assign w_mem_addr = {addr[ADDR_W-1:2], 2'b00};
      end
   endgenerate

   assign w_accept = (r_state == S_IDLE) && req;

   always_comb begin
      w_legal = 1'b0;
      w_misal = 1'b0;
      case (op)
         OP_LB, OP_LBU, OP_SB: w_legal = 1'b1;
         OP_LH, OP_LHU, OP_SH: begin
            w_legal = 1'b1;
            w_misal = addr[0];
         end
         OP_LW, OP_SW: begin
            w_legal = 1'b1;
            w_misal = (addr[1:0] != 2'b00);
         end
         default: w_legal = 1'b0;
      endcase
      w_acc_err = !w_legal || w_misal;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; rejected requests skip memory and go straight to RESP
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               if (w_acc_err)        w_next = S_RESP;
               else if (op == OP_SW) w_next = S_WR;
               else                  w_next = S_RD;
            end
         end
         S_RD:    w_next = r_op[3] ? S_WR : S_RESP;
         S_WR:    w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      ready  = (r_state == S_IDLE);
      done   = (r_state == S_RESP);
      err    = (r_state == S_RESP) && r_err;
      mem_WE = (r_state == S_WR) && !rst;
   end

   // Lane selection and extension of the fetched word for loads
   always_comb begin
      w_byte = 8'h00;
      case (r_lane)
         2'd0:    w_byte = mem_D_out[7:0];
         2'd1:    w_byte = mem_D_out[15:8];
         2'd2:    w_byte = mem_D_out[23:16];
         default: w_byte = mem_D_out[31:24];
      endcase
      w_half = r_lane[1] ? mem_D_out[31:16] : mem_D_out[15:0];
      case (r_op[1:0])
         2'b00:   w_load = r_op[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = r_op[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = mem_D_out;
      endcase
   end

   // Read-modify-write merge: only the addressed lane takes store data
   always_comb begin
      w_merged = mem_D_out;
      if (r_op[1:0] == 2'b00) begin
         case (r_lane)
            2'd0:    w_merged[7:0]   = r_wdata[7:0];
            2'd1:    w_merged[15:8]  = r_wdata[7:0];
            2'd2:    w_merged[23:16] = r_wdata[7:0];
            default: w_merged[31:24] = r_wdata[7:0];
         endcase
      end else if (r_lane[1]) begin
         w_merged[31:16] = r_wdata;
      end else begin
         w_merged[15:0] = r_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= 4'h0;
         r_lane   <= 2'b00;
         r_wdata  <= 16'h0;
         r_err    <= 1'b0;
         rdata    <= 32'h0;
         mem_A_in <= '0;
         mem_D_in <= 32'h0;
      end else begin
         if (w_accept) begin
            r_op    <= op;
            r_lane  <= addr[1:0];
            r_wdata <= wdata[15:0];
            r_err   <= w_acc_err;
            if (w_acc_err) begin
               rdata <= 32'h0;
            end else begin
               mem_A_in <= w_mem_addr;
               if (op == OP_SW) mem_D_in <= wdata;
            end
         end
         if (r_state == S_RD) begin
            if (r_op[3]) mem_D_in <= w_merged;
            else         rdata    <= w_load;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// tb_lsu_mem_ctrl : table-driven check of lsu_mem_ctrl against a behavioural word memory
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [3:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready, done, err, mem_WE;
   logic [31:0] rdata, mem_A_in, mem_D_in, mem_D_out;

   logic [31:0] mem [0:15];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.WORD_ADDR(1), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .ready(ready), .done(done), .err(err), .rdata(rdata),
      .mem_A_in(mem_A_in), .mem_D_in(mem_D_in), .mem_WE(mem_WE),
      .mem_D_out(mem_D_out)
   );

   assign mem_D_out = mem[mem_A_in[3:0]];
   always @(posedge clk) if (mem_WE) mem[mem_A_in[3:0]] <= mem_D_in;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic        err;
      logic        chk_rd;
      logic [31:0] rd;
      int          we;
      int          widx;
      logic [31:0] word;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic add(input string nm, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] wd, input int lat, input logic e,
                      input logic crd, input logic [31:0] rd, input int we,
                      input int widx, input logic [31:0] word);
      vec_t v;
      v.name = nm; v.op = o; v.addr = a; v.wdata = wd; v.lat = lat; v.err = e;
      v.chk_rd = crd; v.rd = rd; v.we = we; v.widx = widx; v.word = word;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input vec_t v);
      int cyc, wes, wait_n;
      logic [31:0] wa, wd;
      wait_n = 0;
      while (!ready && wait_n < 10) begin
         @(negedge clk);
         wait_n++;
      end
      chk({v.name, "_ready"}, {31'h0, ready}, 32'h1);
      req = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      cyc = 1; wes = 0; wa = 32'hx; wd = 32'hx;
      while (cyc < 10) begin
         if (mem_WE) begin
            wes++; wa = mem_A_in; wd = mem_D_in;
         end
         if (done) break;
         @(negedge clk);
         cyc++;
      end
      chk({v.name, "_lat"}, cyc, v.lat);
      chk({v.name, "_err"}, {31'h0, err}, {31'h0, v.err});
      if (v.chk_rd) chk({v.name, "_rdata"}, rdata, v.rd);
      chk({v.name, "_we"}, wes, v.we);
      if (v.we == 1) begin
         chk({v.name, "_waddr"}, wa, v.addr >> 2);
         chk({v.name, "_wdata"}, wd, v.word);
      end
      @(negedge clk);
      chk({v.name, "_mem"}, mem[v.widx], v.word);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn, wes, d1, d2;
      logic [31:0] rd2;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rst = 1'b1; req = 1'b0; op = 4'h0; addr = 32'h0; wdata = 32'h0;

      add("sw_w1",   4'b1010, 32'h4, 32'hDEADBEEF, 2, 0, 0, 0, 1, 1, 32'hDEADBEEF);
      add("lw_w1",   4'b0010, 32'h4, 32'h0, 2, 0, 1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
      add("sw_w1b",  4'b1010, 32'h4, 32'h8012F0A5, 2, 0, 0, 0, 1, 1, 32'h8012F0A5);
      add("lb_4",    4'b0000, 32'h4, 32'h0, 2, 0, 1, 32'hFFFFFFA5, 0, 1, 32'h8012F0A5);
      add("lbu_5",   4'b0100, 32'h5, 32'h0, 2, 0, 1, 32'h000000F0, 0, 1, 32'h8012F0A5);
      add("lh_6",    4'b0001, 32'h6, 32'h0, 2, 0, 1, 32'hFFFF8012, 0, 1, 32'h8012F0A5);
      add("lhu_6",   4'b0101, 32'h6, 32'h0, 2, 0, 1, 32'h00008012, 0, 1, 32'h8012F0A5);
      add("lb_7",    4'b0000, 32'h7, 32'h0, 2, 0, 1, 32'hFFFFFF80, 0, 1, 32'h8012F0A5);
      add("lhu_4",   4'b0101, 32'h4, 32'h0, 2, 0, 1, 32'h0000F0A5, 0, 1, 32'h8012F0A5);
      add("sw_w2",   4'b1010, 32'h8, 32'h11223344, 2, 0, 0, 0, 1, 2, 32'h11223344);
      add("sb_9",    4'b1000, 32'h9, 32'hFFFFFFAB, 3, 0, 0, 0, 1, 2, 32'h1122AB44);
      add("sh_a",    4'b1001, 32'hA, 32'h1234CDEF, 3, 0, 0, 0, 1, 2, 32'hCDEFAB44);
      add("lw_8",    4'b0010, 32'h8, 32'h0, 2, 0, 1, 32'hCDEFAB44, 0, 2, 32'hCDEFAB44);
      add("lbu_b",   4'b0100, 32'hB, 32'h0, 2, 0, 1, 32'h000000CD, 0, 2, 32'hCDEFAB44);
      add("lw_mis",  4'b0010, 32'h6, 32'h0, 1, 1, 1, 32'h0, 0, 1, 32'h8012F0A5);
      add("lb_4b",   4'b0000, 32'h4, 32'h0, 2, 0, 1, 32'hFFFFFFA5, 0, 1, 32'h8012F0A5);
      add("sh_mis",  4'b1001, 32'h3, 32'h5555, 1, 1, 1, 32'h0, 0, 0, 32'h0);
      add("lb_4c",   4'b0000, 32'h4, 32'h0, 2, 0, 1, 32'hFFFFFFA5, 0, 1, 32'h8012F0A5);
      add("sw_bad",  4'b0111, 32'h0, 32'h77777777, 1, 1, 1, 32'h0, 0, 0, 32'h0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", {31'h0, ready}, 32'h1);
      chk("rst_done",  {31'h0, done},  32'h0);
      chk("rst_err",   {31'h0, err},   32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_we",    {31'h0, mem_WE}, 32'h0);
      chk("rst_addr",  mem_A_in, 32'h0);
      chk("rst_din",   mem_D_in, 32'h0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Busy SB with req held; the changed request is taken only once idle
      mem[3] = 32'h55667788;
      @(negedge clk);
      req = 1'b1; op = 4'b1000; addr = 32'hC; wdata = 32'h00000011;
      @(posedge clk);
      dn = 0; wes = 0; d1 = 0; d2 = 0; rd2 = 32'h0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) begin
            op = 4'b0010; addr = 32'hC;
            chk("busy_ready", {31'h0, ready}, 32'h0);
         end
         if (c == 4) chk("idle_ready", {31'h0, ready}, 32'h1);
         if (mem_WE) wes++;
         if (done) begin
            dn++;
            if (dn == 1) d1 = c;
            else begin d2 = c; rd2 = rdata; end
         end
         if (c == 5) req = 1'b0;
      end
      chk("held_dones", dn, 2);
      chk("held_done1", d1, 3);
      chk("held_done2", d2, 6);
      chk("held_we",    wes, 1);
      chk("held_rdata", rd2, 32'h55667711);
      chk("held_mem",   mem[3], 32'h55667711);

      // Reset during WR of SW 0x8
      @(negedge clk);
      req = 1'b1; op = 4'b1010; addr = 32'h8; wdata = 32'h99999999;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      chk("rstwr_we_pre", {31'h0, mem_WE}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rstwr_we", {31'h0, mem_WE}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("rstwr_ready", {31'h0, ready}, 32'h1);
      dn = 0;
      for (int c = 0; c < 3; c++) begin
         if (done) dn++;
         @(negedge clk);
      end
      chk("rstwr_nodone", dn, 0);
      chk("rstwr_mem", mem[2], 32'hCDEFAB44);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
